// File: rtl/multi_pattern_comparator_pkg.sv
// Shared stream geometry for the sniffer datapath.
// Also holds the helper that sizes the compare window from the pattern length.
package sniffer_pkg;

   localparam int BYTE_W   = 8;
   localparam int STREAM_W = 32;
   localparam int LANES    = 4;

   // Enough whole words so every lane offset can see a full pattern.
   function automatic int win_words(input int pat_bytes);
      return (pat_bytes + 2 * (LANES - 1)) / LANES;
   endfunction

endpackage

// File: rtl/multi_pattern_comparator_if.sv
// Stream, pattern-programming and status bundle of the multi-pattern comparator.
// The master side drives stream and pattern writes; the slave side returns status.
interface multi_pattern_comparator_if #(
   parameter int NUM_PAT   = 4,
   parameter int PAT_BYTES = 4,
   parameter int CNT_W     = 16
);

   localparam int SEL_W = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1;

   logic                   clear;
   logic                   data_valid;
   logic [31:0]            data_in;
   logic                   pat_load;
   logic [SEL_W-1:0]       pat_sel;
   logic [8*PAT_BYTES-1:0] pat_in;
   logic                   pat_en_in;

   logic [NUM_PAT-1:0]     match_vec;
   logic                   match_any;
   logic [SEL_W-1:0]       first_idx;
   logic [1:0]             first_off;
   logic [CNT_W-1:0]       hit_count;
   logic [31:0]            data_out;
   logic                   data_out_valid;

   modport master (
      output clear, data_valid, data_in, pat_load, pat_sel, pat_in, pat_en_in,
      input  match_vec, match_any, first_idx, first_off, hit_count, data_out, data_out_valid
   );

   modport slave (
      input  clear, data_valid, data_in, pat_load, pat_sel, pat_in, pat_en_in,
      output match_vec, match_any, first_idx, first_off, hit_count, data_out, data_out_valid
   );

endinterface

// File: rtl/multi_pattern_comparator_lane_cmp.sv
// One pattern slot compared against the window at each of the four byte offsets.
// Purely combinational; qualification comes from the owner of the window.
module pattern_lane_cmp
   import sniffer_pkg::*;
#(
   parameter int PAT_BYTES = 4,
   parameter int WIN_W     = 64
) (
   input  logic [WIN_W-1:0]              win,
   input  logic [BYTE_W*PAT_BYTES-1:0]   pat,
   input  logic                          en,
   input  logic                          qual,
   output logic [LANES-1:0]              hit
);

   for (genvar o = 0; o < LANES; o++) begin : g_off
      assign hit[o] = en && qual && (win[BYTE_W*o +: BYTE_W*PAT_BYTES] == pat);
   end

endmodule

// File: rtl/multi_pattern_comparator.sv
// Matches a little-byte-order word stream against NUM_PAT programmable byte patterns
// at every byte alignment; keeps sticky flags, first hit, a saturating count and a delayed copy.
module multi_pattern_comparator
   import sniffer_pkg::*;
#(
   parameter int NUM_PAT   = 4,
   parameter int PAT_BYTES = 4,
   parameter int CNT_W     = 16
) (
   input logic                   clk,
   input logic                   n_rst,
   multi_pattern_comparator_if.slave bus
);

   localparam int WIN    = win_words(PAT_BYTES);
   localparam int WIN_W  = WIN * STREAM_W;
   localparam int FILL_W = $clog2(WIN + 1);
   localparam int SEL_W  = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1;
   localparam int HIT_W  = $clog2(LANES * NUM_PAT + 1);

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] acc,
                                                input logic [HIT_W-1:0] inc);
      logic [CNT_W+HIT_W:0] sum;
      sum = (CNT_W+HIT_W+1)'(acc) + (CNT_W+HIT_W+1)'(inc);
      return (sum > (CNT_W+HIT_W+1)'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
   endfunction

   logic [8*PAT_BYTES-1:0] pat_r [NUM_PAT];
   logic [NUM_PAT-1:0]     en_r;

   logic [WIN_W-1:0]       win_p0;
   logic [FILL_W-1:0]      fill_p0;
   logic                   vld_p0;
   logic [31:0]            data_out_p0;
   logic                   vld_out_p0;

   logic [NUM_PAT-1:0]     match_vec_p1;
   logic [SEL_W-1:0]       first_idx_p1;
   logic [1:0]             first_off_p1;
   logic [CNT_W-1:0]       hit_count_p1;

   logic                   full;
   logic                   qual;
   logic [LANES-1:0]       hit [NUM_PAT];
   logic [NUM_PAT-1:0]     hit_or;
   logic                   any_hit;
   logic [HIT_W-1:0]       n_hits;
   logic [SEL_W-1:0]       f_idx;
   logic [1:0]             f_off;
   logic [NUM_PAT-1:0]     load_mask;
   logic                   match_any;

   assign full      = (fill_p0 == FILL_W'(WIN));
   // Only a window refreshed on the previous edge is compared, so each byte start is tested once.
   assign qual      = full && vld_p0;
   assign match_any = |match_vec_p1;
   assign load_mask = bus.pat_load ? (NUM_PAT'(1) << bus.pat_sel) : '0;

   for (genvar g = 0; g < NUM_PAT; g++) begin : g_lane
      pattern_lane_cmp #(
         .PAT_BYTES(PAT_BYTES),
         .WIN_W    (WIN_W)
      ) u_lane (
         .win (win_p0),
         .pat (pat_r[g]),
         .en  (en_r[g]),
         .qual(qual),
         .hit (hit[g])
      );
   end

   // Priority: lowest slot first, then lowest offset.
   always_comb begin
      logic found;
      found   = 1'b0;
      n_hits  = '0;
      f_idx   = '0;
      f_off   = '0;
      hit_or  = '0;
      for (int p = 0; p < NUM_PAT; p++) begin
         hit_or[p] = |hit[p];
         for (int o = 0; o < LANES; o++) begin
            if (hit[p][o]) begin
               n_hits = n_hits + HIT_W'(1);
               if (!found) begin
                  found = 1'b1;
                  f_idx = SEL_W'(p);
                  f_off = 2'(o);
               end
            end
         end
      end
      any_hit = found;
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         win_p0       <= '0;
         fill_p0      <= '0;
         vld_p0       <= 1'b0;
         data_out_p0  <= '0;
         vld_out_p0   <= 1'b0;
         match_vec_p1 <= '0;
         first_idx_p1 <= '0;
         first_off_p1 <= '0;
         hit_count_p1 <= '0;
         en_r         <= '0;
         for (int p = 0; p < NUM_PAT; p++) pat_r[p] <= '0;
      end else begin
         if (bus.clear) begin
            win_p0       <= '0;
            fill_p0      <= '0;
            vld_p0       <= 1'b0;
            data_out_p0  <= '0;
            vld_out_p0   <= 1'b0;
            match_vec_p1 <= '0;
            first_idx_p1 <= '0;
            first_off_p1 <= '0;
            hit_count_p1 <= '0;
         end else begin
            // Stage p0: window shift, fill tracking and pass-through of the evicted word.
            vld_p0     <= bus.data_valid;
            vld_out_p0 <= bus.data_valid && full;
            if (bus.data_valid) begin
               win_p0 <= (win_p0 >> STREAM_W) | (WIN_W'(bus.data_in) << (WIN_W - STREAM_W));
               if (full) data_out_p0 <= win_p0[STREAM_W-1:0];
               else      fill_p0     <= fill_p0 + FILL_W'(1);
            end
            // Stage p1: status from the compare of the fresh window; a reload drops its slot flag.
            match_vec_p1 <= (match_vec_p1 | hit_or) & ~load_mask;
            if (!match_any && any_hit) begin
               first_idx_p1 <= f_idx;
               first_off_p1 <= f_off;
            end
            hit_count_p1 <= sat_add(hit_count_p1, n_hits);
         end
         if (bus.pat_load) begin
            pat_r[bus.pat_sel] <= bus.pat_in;
            en_r[bus.pat_sel]  <= bus.pat_en_in;
         end
      end
   end

   assign bus.match_vec      = match_vec_p1;
   assign bus.match_any      = match_any;
   assign bus.first_idx      = first_idx_p1;
   assign bus.first_off      = first_off_p1;
   assign bus.hit_count      = hit_count_p1;
   assign bus.data_out       = data_out_p0;
   assign bus.data_out_valid = vld_out_p0;

endmodule
